// File: rtl/s_mem_verify.sv
// S-memory read-back checker: sweeps S[0..255] once per start request and reports pass/err_cnt/err_addr.
// Define PERM_CHECK_EN for the permutation check (post-KSA); otherwise each S[k] must equal k (post-init).
module s_mem_verify (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] addr,
    output logic       wren,
    input  logic [7:0] rddata,
    output logic       pass,
    output logic [8:0] err_cnt,
    output logic [7:0] err_addr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state_r;
    logic       rdy_r;
    logic [7:0] addr_r;
    logic       pass_r;
    logic [8:0] err_cnt_r;
    logic [7:0] err_addr_r;

    logic       cmp_valid_s;
    logic [7:0] cmp_addr_s;
    logic       fail_s;

`ifdef PERM_CHECK_EN
    logic [255:0] seen_r;

    function automatic logic check_fail(input logic [255:0] seen, input logic [7:0] data);
        return seen[data];
    endfunction

    assign fail_s = check_fail(seen_r, rddata);

    // Seen-value tracking: cleared on reset and on each accepted start, set by every passing compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_r <= 256'd0;
        end else if ((state_r == ST_IDLE) && en) begin
            seen_r <= 256'd0;
        end else if (cmp_valid_s && !fail_s) begin
            seen_r[rddata] <= 1'b1;
        end else begin
            seen_r <= seen_r;
        end
    end
`else
    function automatic logic check_fail(input logic [7:0] data, input logic [7:0] expect_v);
        return (data != expect_v);
    endfunction

    assign fail_s = check_fail(rddata, cmp_addr_s);
`endif

    // rddata lags addr by one cycle; addr_r is already 0 in DRAIN so the wrap yields 255 there.
    assign cmp_valid_s = ((state_r == ST_READ) && (addr_r != 8'd0)) || (state_r == ST_DRAIN);
    assign cmp_addr_s  = addr_r - 8'd1;

    // Sequencer, address generator and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rdy_r      <= 1'b1;
            addr_r     <= 8'd0;
            pass_r     <= 1'b0;
            err_cnt_r  <= 9'd0;
            err_addr_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        state_r    <= ST_READ;
                        rdy_r      <= 1'b0;
                        addr_r     <= 8'd0;
                        pass_r     <= 1'b0;
                        err_cnt_r  <= 9'd0;
                        err_addr_r <= 8'd0;
                    end else begin
                        state_r <= ST_IDLE;
                        rdy_r   <= 1'b1;
                        addr_r  <= 8'd0;
                    end
                end
                ST_READ: begin
                    if (addr_r == 8'd255) begin
                        state_r <= ST_DRAIN;
                        addr_r  <= 8'd0;
                    end else begin
                        addr_r  <= addr_r + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    rdy_r   <= 1'b1;
                    pass_r  <= (err_cnt_r == 9'd0);
                end
                default: begin
                    state_r <= ST_IDLE;
                    rdy_r   <= 1'b1;
                    addr_r  <= 8'd0;
                end
            endcase

            if (cmp_valid_s && fail_s) begin
                if (err_cnt_r != 9'd256) begin
                    err_cnt_r <= err_cnt_r + 9'd1;
                end else begin
                    err_cnt_r <= err_cnt_r;
                end
                if (err_cnt_r == 9'd0) begin
                    err_addr_r <= cmp_addr_s;
                end else begin
                    err_addr_r <= err_addr_r;
                end
            end
        end
    end

    assign rdy      = rdy_r;
    assign addr     = addr_r;
    assign wren     = 1'b0;
    assign pass     = pass_r;
    assign err_cnt  = err_cnt_r;
    assign err_addr = err_addr_r;

endmodule

// File: tb/tb_s_mem_verify.sv
// Self-checking bench for s_mem_verify: S-memory model, run-level reference model and per-cycle comparison.
module tb_s_mem_verify;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rdy;
    logic [7:0] addr;
    logic       wren;
    logic [7:0] rddata = 8'd0;
    logic       pass;
    logic [8:0] err_cnt;
    logic [7:0] err_addr;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: run phase (-1 = idle) and the results it publishes.
    int m_phase = -1;
    int m_cnt   = 0;
    int m_eaddr = 0;
    int m_pass  = 0;
    int pend_cnt   = 0;
    int pend_addr  = 0;
    bit chk_on     = 1'b0;

    s_mem_verify dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rdy      (rdy),
        .addr     (addr),
        .wren     (wren),
        .rddata   (rddata),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rddata <= mem[addr];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected results of one sweep over the current memory contents.
    function automatic void ref_results(output int cnt, output int first);
        bit seen [256];
        cnt   = 0;
        first = 0;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 256; k++) begin
            bit bad;
`ifdef PERM_CHECK_EN
            bad = seen[mem[k]];
            if (!bad) seen[mem[k]] = 1'b1;
`else
            bad = (int'(mem[k]) != k);
`endif
            if (bad) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= -1; m_cnt <= 0; m_eaddr <= 0; m_pass <= 0;
        end else if (m_phase < 0) begin
            if (en) begin
                m_phase <= 0; m_cnt <= 0; m_eaddr <= 0; m_pass <= 0;
            end
        end else if (m_phase == 257) begin
            m_phase <= -1;
            m_cnt   <= pend_cnt;
            m_eaddr <= pend_addr;
            m_pass  <= (pend_cnt == 0) ? 1 : 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(posedge clk) if (rst) chk_on <= 1'b1;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rdy", int'(rdy), (m_phase < 0) ? 1 : 0);
            chk("wren", int'(wren), 0);
            if (m_phase <= 255)
                chk("addr", int'(addr), (m_phase < 0) ? 0 : m_phase);
            if (m_phase <= 1) begin
                chk("err_cnt", int'(err_cnt), m_cnt);
                chk("err_addr", int'(err_addr), m_eaddr);
                chk("pass", int'(pass), m_pass);
            end
        end
    end

    task automatic mem_identity();
        for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    endtask

    task automatic run_once(output int lat);
        int c, f;
        ref_results(c, f);
        pend_cnt  = c;
        pend_addr = f;
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        lat = 0;
        while (!rdy && lat < 400) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic check_results(input string tag, input int cnt, input int eaddr, input int ps);
        chk({tag, ".err_cnt"}, int'(err_cnt), cnt);
        chk({tag, ".err_addr"}, int'(err_addr), eaddr);
        chk({tag, ".pass"}, int'(pass), ps);
    endtask

    initial begin
        int lat, c, f, hi_run, hi_max, rises;
        logic prev_rdy;
        mem_identity();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_results("reset", 0, 0, 0);
        chk("reset.rdy", int'(rdy), 1);

        // Clean identity memory: full latency and a passing result.
        mem_identity();
        run_once(lat);
        chk("latency", lat, 258);
        check_results("clean", 0, 0, 1);

`ifdef PERM_CHECK_EN
        mem_identity();
        mem[3] = 8'd200; mem[200] = 8'd3;
        run_once(lat);
        chk("swap.pend_cnt", pend_cnt, 0);
        check_results("swap", 0, 0, 1);

        mem_identity();
        mem[5] = 8'd9;
        run_once(lat);
        chk("dup.pend_addr", pend_addr, 9);
        check_results("dup", 1, 9, 0);
`else
        mem_identity();
        mem[17] = 8'h00; mem[200] = 8'h05;
        run_once(lat);
        chk("two_bad.pend_cnt", pend_cnt, 2);
        check_results("two_bad", 2, 17, 0);

        for (int k = 0; k < 256; k++) mem[k] = 8'(k + 1);
        run_once(lat);
        check_results("all_bad", 256, 0, 0);
`endif

        // Reset in the middle of a run after a passing run.
        mem_identity();
        run_once(lat);
        check_results("pre_rst", 0, 0, 1);
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        repeat (99) @(negedge clk);
        en = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        chk("mid_rst.rdy", int'(rdy), 1);
        chk("mid_rst.addr", int'(addr), 0);
        check_results("mid_rst", 0, 0, 0);
        @(negedge clk);
        chk("mid_rst.en_ignored", int'(rdy), 1);
        run_once(lat);
        chk("post_rst.latency", lat, 258);
        check_results("post_rst", 0, 0, 1);

        // en held high: back-to-back runs with a single idle cycle between them.
        mem_identity();
        ref_results(c, f);
        pend_cnt = c; pend_addr = f;
        en = 1'b1;
        hi_run = 0; hi_max = 0; rises = 0; prev_rdy = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rdy) begin
                hi_run++;
                if (hi_run > hi_max) hi_max = hi_run;
                if (!prev_rdy) rises++;
            end else begin
                hi_run = 0;
            end
            prev_rdy = rdy;
        end
        en = 1'b0;
        lat = 0;
        while (!rdy && lat < 400) begin
            lat++;
            @(negedge clk);
        end
        chk("held.runs_done", rises, 2);
        chk("held.rdy_width", hi_max, 1);
        chk("held.finish", int'(rdy), 1);
        check_results("held", 0, 0, 1);

        // Randomized memory contents against the reference model.
        for (int r = 0; r < 8; r++) begin
            int nbad;
            mem_identity();
`ifdef PERM_CHECK_EN
            for (int i = 255; i > 0; i--) begin
                int j;
                logic [7:0] t;
                j = $urandom_range(i, 0);
                t = mem[i]; mem[i] = mem[j]; mem[j] = t;
            end
`endif
            nbad = $urandom_range(4, 0);
            for (int b = 0; b < nbad; b++) mem[$urandom_range(255, 0)] = 8'($urandom);
            if (r == 7) for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
            run_once(lat);
            chk("rand.latency", lat, 258);
            check_results("rand", pend_cnt, pend_addr, (pend_cnt == 0) ? 1 : 0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s_mem_verify.md
S_MEM_VERIFY -- requirements
Module: s_mem_verify

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  start request; sampled only while rdy=1.
- rdy  output  1  high when idle and results are valid.
- addr  output  8  S-memory read address.
- wren  output  1  S-memory write enable; tied to 0.
- rddata  input  8  S-memory read data, valid one cycle after addr.
- pass  output  1  result of the last completed run.
- err_cnt  output  9  number of failing addresses in the last run (0..256).
- err_addr  output  8  first failing address of the last run; 0 when err_cnt=0.
REQ-002 The reset is synchronous and active-high; there is one clock, clk.

Function
REQ-003 The block SHALL be the reader counterpart of the S-memory init writer: it reads S[0..255] back and checks the contents.
REQ-004 The block SHALL implement states IDLE, READ, DRAIN and DONE.
REQ-005 In IDLE, rdy=1; an edge with en=1 SHALL move the block to READ, drop rdy on the next cycle, and clear err_cnt, err_addr, pass and the check state.
REQ-006 In READ, addr SHALL start at 0 and increment by 1 every cycle through 255, back-to-back with no gaps (256 cycles).
REQ-007 The block SHALL compare rddata for address k in the cycle after addr=k, pipelined one stage behind the address.
REQ-008 After addr=255 is issued, the block SHALL move to DRAIN, compare the data for address 255, then move to DONE.
REQ-009 DONE SHALL last one cycle.
  - It latches pass = (err_cnt==0).
  - It then returns to IDLE with rdy=1.
  - The total from the en-accept edge to rdy=1 is 258 cycles.
REQ-010 On each failing compare, err_cnt SHALL increment.
  - err_addr SHALL capture the address only on the first failure of the run.
  - err_cnt SHALL saturate at 256 and never wrap.
REQ-011 en asserted while rdy=0 SHALL be ignored.
  - If en is held high continuously, a new run SHALL start on the IDLE cycle, so rdy is high for exactly one cycle between runs.
REQ-012 pass, err_cnt and err_addr SHALL stay stable from DONE until the next accepted en.
REQ-013 addr SHALL hold 0 in IDLE, and wren SHALL always be 0.

Reset
REQ-014 While rst=1 at an edge, the block SHALL go to IDLE with rdy=1, addr=0, pass=0, err_cnt=0 and err_addr=0, and SHALL clear all seen bits.
REQ-015 Reset mid-run SHALL abort the run with no partial results retained; rdy=1 from the first cycle after rst deasserts.
REQ-016 en sampled in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-017 The macro PERM_CHECK_EN selects the check mode; exactly one mode is compiled in.
REQ-018 Without PERM_CHECK_EN, the check SHALL be identity: address k fails if rddata != k.
  - This validates the state after init.
REQ-019 With PERM_CHECK_EN, the check SHALL be permutation, which validates the state after KSA.
  - A 256-bit seen vector is cleared on en-accept.
  - Address k fails if seen[rddata] is already set; otherwise seen[rddata] is set.
  - pass=1 implies S is a permutation of 0..255.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Identity mode, S[i]=i: en for one cycle -> rdy falls next cycle and rises 258 cycles after accept; pass=1, err_cnt=0, err_addr=0.
- Identity mode, S[17]=0x00 and S[200]=0x05: pass=0, err_cnt=2, err_addr=17.
- Permutation mode, S=identity with S[3]=200 and S[200]=3 swapped: pass=1, err_cnt=0.
- Permutation mode, S=identity with S[5]=9 (value 9 duplicated, 5 missing): fail at address 9; pass=0, err_cnt=1, err_addr=9.
- rst pulsed at cycle 100 of a run: next cycle rdy=1, addr=0, err_cnt=0, pass=0; a fresh run then completes normally with pass=1 on identity data.
- en held high for 600 cycles: two complete runs; rdy high for exactly one cycle between them; addr sequence 0..255 with no gaps in each run.
